// File: rtl/comm_chan_arbiter.sv
// comm_chan_arbiter: routes host h2f/f2h byte pipes to one of NUM_CHAN clients by channel address,
// sinking/filling unmapped channels and force-completing stalled transfers via a watchdog.
module comm_chan_arbiter #(
    parameter int          NUM_CHAN  = 4,
    parameter int          TIMEOUT   = 1000,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic                    clk_in,
    input  logic                    resetN_in,
    input  logic [6:0]              chanAddr_in,
    input  logic [7:0]              h2fData_in,
    input  logic                    h2fValid_in,
    output logic                    h2fReady_out,
    output logic [7:0]              f2hData_out,
    output logic                    f2hValid_out,
    input  logic                    f2hReady_in,
    output logic [7:0]              cliH2fData_out,
    output logic [NUM_CHAN-1:0]     cliH2fValid_out,
    input  logic [NUM_CHAN-1:0]     cliH2fReady_in,
    input  logic [8*NUM_CHAN-1:0]   cliF2hData_in,
    input  logic [NUM_CHAN-1:0]     cliF2hValid_in,
    output logic [NUM_CHAN-1:0]     cliF2hReady_out,
    output logic [15:0]             timeoutCount_out,
    output logic [6:0]              lastTimeoutChan_out,
    output logic                    busy_out
);
    typedef enum logic [1:0] {S_IDLE, S_H2F, S_F2H, S_ABORT} stateType;

    stateType              state, stateNext;
    logic [6:0]            sel;
    logic                  isH2f;
    logic [15:0]           stallCnt;
    logic [NUM_CHAN-1:0]   selHot;
    logic [7:0]            selData;
    logic                  selMapped, cliWrRdy, cliRdVld, stallHit;

    always_comb begin
        selHot  = '0;
        selData = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (sel == 7'(k)) begin
                selHot[k] = 1'b1;
                selData   = cliF2hData_in[8*k +: 8];
            end
        end
    end

    assign selMapped = |selHot;
    assign cliWrRdy  = |(cliH2fReady_in & selHot);
    assign cliRdVld  = |(cliF2hValid_in & selHot);
    // Hit on the last stall cycle so that ABORT follows exactly TIMEOUT stalled cycles
    assign stallHit  = (TIMEOUT != 0) && (stallCnt == 16'(TIMEOUT - 1));
    assign cliH2fData_out = resetN_in ? h2fData_in : 8'h00;
    assign busy_out = (state != S_IDLE);

    always_ff @(posedge clk_in or negedge resetN_in) begin
        if (!resetN_in) begin
            state               <= S_IDLE;
            sel                 <= '0;
            isH2f               <= 1'b0;
            stallCnt            <= '0;
            timeoutCount_out    <= '0;
            lastTimeoutChan_out <= '0;
        end else begin
            state <= stateNext;
            if (state == S_IDLE) begin
                sel      <= chanAddr_in;
                isH2f    <= h2fValid_in;
                stallCnt <= '0;
            end else if (state != S_ABORT && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (state == S_ABORT) begin
                timeoutCount_out    <= (timeoutCount_out == 16'hFFFF) ? timeoutCount_out : timeoutCount_out + 16'd1;
                lastTimeoutChan_out <= sel;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  stateNext = h2fValid_in ? S_H2F : (f2hReady_in ? S_F2H : S_IDLE);
            S_H2F:   stateNext = (!selMapped || !h2fValid_in || cliWrRdy) ? S_IDLE : (stallHit ? S_ABORT : S_H2F);
            S_F2H:   stateNext = (!selMapped || !f2hReady_in || cliRdVld) ? S_IDLE : (stallHit ? S_ABORT : S_F2H);
            default: stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        h2fReady_out    = 1'b0;
        f2hValid_out    = 1'b0;
        f2hData_out     = 8'h00;
        cliH2fValid_out = '0;
        cliF2hReady_out = '0;
        case (state)
            S_H2F: begin
                cliH2fValid_out = selHot & {NUM_CHAN{h2fValid_in}};
                h2fReady_out    = selMapped ? cliWrRdy : 1'b1;
            end
            S_F2H: begin
                cliF2hReady_out = selHot & {NUM_CHAN{f2hReady_in}};
                f2hValid_out    = selMapped ? cliRdVld : 1'b1;
                f2hData_out     = selMapped ? selData : FILL_BYTE;
            end
            S_ABORT: begin
                h2fReady_out = isH2f;
                f2hValid_out = !isH2f;
                f2hData_out  = isH2f ? 8'h00 : FILL_BYTE;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_comm_chan_arbiter.sv
// tb_comm_chan_arbiter: directed tests of channel routing, unmapped channels, watchdog and reset.
module tb_comm_chan_arbiter;
    logic        clk_in = 1'b0;
    logic        resetN_in;
    logic [6:0]  chanAddr_in;
    logic [7:0]  h2fData_in;
    logic        h2fValid_in, f2hReady_in;
    logic [3:0]  cliH2fReady_in, cliF2hValid_in;
    logic [31:0] cliF2hData_in;
    logic        h2fReady_out, f2hValid_out, busy_out;
    logic [7:0]  f2hData_out, cliH2fData_out;
    logic [3:0]  cliH2fValid_out, cliF2hReady_out;
    logic [15:0] timeoutCount_out;
    logic [6:0]  lastTimeoutChan_out;
    logic        zH2fReady, zF2hValid, zBusy;
    logic [7:0]  zF2hData, zCliH2fData;
    logic [3:0]  zCliH2fValid, zCliF2hReady;
    logic [15:0] zTimeoutCount;
    logic [6:0]  zLastChan;
    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    comm_chan_arbiter #(.NUM_CHAN(4), .TIMEOUT(8), .FILL_BYTE(8'hFF)) dut (
        .clk_in(clk_in), .resetN_in(resetN_in), .chanAddr_in(chanAddr_in),
        .h2fData_in(h2fData_in), .h2fValid_in(h2fValid_in), .h2fReady_out(h2fReady_out),
        .f2hData_out(f2hData_out), .f2hValid_out(f2hValid_out), .f2hReady_in(f2hReady_in),
        .cliH2fData_out(cliH2fData_out), .cliH2fValid_out(cliH2fValid_out), .cliH2fReady_in(cliH2fReady_in),
        .cliF2hData_in(cliF2hData_in), .cliF2hValid_in(cliF2hValid_in), .cliF2hReady_out(cliF2hReady_out),
        .timeoutCount_out(timeoutCount_out), .lastTimeoutChan_out(lastTimeoutChan_out), .busy_out(busy_out)
    );

    comm_chan_arbiter #(.NUM_CHAN(4), .TIMEOUT(0), .FILL_BYTE(8'hFF)) dutNoWd (
        .clk_in(clk_in), .resetN_in(resetN_in), .chanAddr_in(chanAddr_in),
        .h2fData_in(h2fData_in), .h2fValid_in(h2fValid_in), .h2fReady_out(zH2fReady),
        .f2hData_out(zF2hData), .f2hValid_out(zF2hValid), .f2hReady_in(f2hReady_in),
        .cliH2fData_out(zCliH2fData), .cliH2fValid_out(zCliH2fValid), .cliH2fReady_in(cliH2fReady_in),
        .cliF2hData_in(cliF2hData_in), .cliF2hValid_in(cliF2hValid_in), .cliF2hReady_out(zCliF2hReady),
        .timeoutCount_out(zTimeoutCount), .lastTimeoutChan_out(zLastChan), .busy_out(zBusy)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic idleInputs();
        h2fValid_in = 0; f2hReady_in = 0; cliH2fReady_in = 0; cliF2hValid_in = 0;
    endtask

    task automatic test_reset();
        resetN_in = 0; chanAddr_in = 0; h2fData_in = 8'h77; cliF2hData_in = 0;
        idleInputs();
        h2fValid_in = 1; f2hReady_in = 1;
        tick(2);
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
        checks++; if (cliH2fData_out !== 8'h00) begin failures++; $display("FAIL reset_clidata got=%h exp=00", cliH2fData_out); end
        checks++; if ({h2fReady_out, f2hValid_out, f2hData_out, cliH2fValid_out, cliF2hReady_out} !== 18'h0) begin
            failures++; $display("FAIL reset_outs got=%b/%b/%h/%b/%b exp=0", h2fReady_out, f2hValid_out, f2hData_out, cliH2fValid_out, cliF2hReady_out); end
        checks++; if ({timeoutCount_out, lastTimeoutChan_out} !== 23'h0) begin
            failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", timeoutCount_out, lastTimeoutChan_out); end
        idleInputs();
        @(negedge clk_in); resetN_in = 1;
        tick();
    endtask

    task automatic test_write();
        chanAddr_in = 2; h2fData_in = 8'hA5; h2fValid_in = 1; cliH2fReady_in = 4'b0100;
        tick();
        checks++; if (cliH2fValid_out !== 4'b0100) begin failures++; $display("FAIL wr_strobe got=%b exp=0100", cliH2fValid_out); end
        checks++; if (h2fReady_out !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", h2fReady_out); end
        checks++; if (cliH2fData_out !== 8'hA5) begin failures++; $display("FAIL wr_data got=%h exp=a5", cliH2fData_out); end
        tick(); idleInputs(); #1;
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL wr_idle got=%b exp=0", busy_out); end
    endtask

    task automatic test_read();
        chanAddr_in = 1; f2hReady_in = 1; cliF2hValid_in = 4'b0010; cliF2hData_in = 32'h11_22_3C_44;
        tick();
        chanAddr_in = 2; #1;
        checks++; if (f2hValid_out !== 1'b1 || f2hData_out !== 8'h3C) begin
            failures++; $display("FAIL rd_data got=%b/%h exp=1/3c", f2hValid_out, f2hData_out); end
        checks++; if (cliF2hReady_out !== 4'b0010 || cliH2fValid_out !== 4'b0000) begin
            failures++; $display("FAIL rd_strobe got=%b/%b exp=0010/0000", cliF2hReady_out, cliH2fValid_out); end
        tick(); idleInputs(); #1;
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b exp=0", busy_out); end
    endtask

    task automatic test_unmapped();
        chanAddr_in = 7'h50; h2fValid_in = 1;
        tick();
        checks++; if (h2fReady_out !== 1'b1 || cliH2fValid_out !== 4'b0000) begin
            failures++; $display("FAIL um_wr got=%b/%b exp=1/0000", h2fReady_out, cliH2fValid_out); end
        tick(); idleInputs();
        tick();
        f2hReady_in = 1;
        tick();
        checks++; if (f2hValid_out !== 1'b1 || f2hData_out !== 8'hFF || cliF2hReady_out !== 4'b0000) begin
            failures++; $display("FAIL um_rd got=%b/%h/%b exp=1/ff/0000", f2hValid_out, f2hData_out, cliF2hReady_out); end
        tick(); idleInputs();
        tick();
    endtask

    task automatic test_watchdog();
        chanAddr_in = 3; h2fValid_in = 1;
        tick(8);
        checks++; if (busy_out !== 1'b1 || h2fReady_out !== 1'b0 || timeoutCount_out !== 16'd0) begin
            failures++; $display("FAIL wd_wr_pre got=%b/%b/%0d exp=1/0/0", busy_out, h2fReady_out, timeoutCount_out); end
        tick();
        checks++; if (h2fReady_out !== 1'b1 || cliH2fValid_out !== 4'b0000) begin
            failures++; $display("FAIL wd_wr_abort got=%b/%b exp=1/0000", h2fReady_out, cliH2fValid_out); end
        tick(); idleInputs(); #1;
        checks++; if (timeoutCount_out !== 16'd1 || lastTimeoutChan_out !== 7'd3 || busy_out !== 1'b0) begin
            failures++; $display("FAIL wd_wr_cnt got=%0d/%0d/%b exp=1/3/0", timeoutCount_out, lastTimeoutChan_out, busy_out); end
        tick();
        f2hReady_in = 1;
        tick(9);
        checks++; if (f2hValid_out !== 1'b1 || f2hData_out !== 8'hFF || cliF2hReady_out !== 4'b0000) begin
            failures++; $display("FAIL wd_rd_abort got=%b/%h/%b exp=1/ff/0000", f2hValid_out, f2hData_out, cliF2hReady_out); end
        tick(); idleInputs(); #1;
        checks++; if (timeoutCount_out !== 16'd2 || lastTimeoutChan_out !== 7'd3) begin
            failures++; $display("FAIL wd_rd_cnt got=%0d/%0d exp=2/3", timeoutCount_out, lastTimeoutChan_out); end
        tick();
    endtask

    task automatic test_boundary_beat();
        chanAddr_in = 3; h2fValid_in = 1;
        tick(8);
        cliH2fReady_in = 4'b1000; #1;
        checks++; if (h2fReady_out !== 1'b1 || cliH2fValid_out !== 4'b1000) begin
            failures++; $display("FAIL bnd_beat got=%b/%b exp=1/1000", h2fReady_out, cliH2fValid_out); end
        tick(); idleInputs(); #1;
        checks++; if (busy_out !== 1'b0 || timeoutCount_out !== 16'd2) begin
            failures++; $display("FAIL bnd_cnt got=%b/%0d exp=0/2", busy_out, timeoutCount_out); end
        tick();
    endtask

    task automatic test_priority();
        chanAddr_in = 0; h2fValid_in = 1; f2hReady_in = 1; cliH2fReady_in = 4'b0001; cliF2hValid_in = 4'b0001;
        tick();
        checks++; if (cliH2fValid_out !== 4'b0001 || cliF2hReady_out !== 4'b0000 || h2fReady_out !== 1'b1 || f2hValid_out !== 1'b0) begin
            failures++; $display("FAIL prio got=%b/%b/%b/%b exp=0001/0000/1/0", cliH2fValid_out, cliF2hReady_out, h2fReady_out, f2hValid_out); end
        tick(); idleInputs();
        tick();
    endtask

    task automatic test_reset_mid();
        chanAddr_in = 2; f2hReady_in = 1;
        tick();
        checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", busy_out); end
        #2 resetN_in = 0; #1;
        checks++; if ({busy_out, f2hValid_out, f2hData_out, cliF2hReady_out, h2fReady_out} !== 15'h0) begin
            failures++; $display("FAIL rst_mid_outs got=%b/%b/%h/%b/%b exp=0", busy_out, f2hValid_out, f2hData_out, cliF2hReady_out, h2fReady_out); end
        checks++; if (timeoutCount_out !== 16'd0 || lastTimeoutChan_out !== 7'd0) begin
            failures++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", timeoutCount_out, lastTimeoutChan_out); end
        idleInputs();
        @(negedge clk_in); resetN_in = 1;
        tick();
        chanAddr_in = 0; f2hReady_in = 1; cliF2hValid_in = 4'b0001; cliF2hData_in = 32'h00_00_00_81;
        tick();
        checks++; if (f2hValid_out !== 1'b1 || f2hData_out !== 8'h81 || cliF2hReady_out !== 4'b0001) begin
            failures++; $display("FAIL rst_mid_rd got=%b/%h/%b exp=1/81/0001", f2hValid_out, f2hData_out, cliF2hReady_out); end
        tick(); idleInputs();
        tick();
    endtask

    task automatic test_no_watchdog();
        chanAddr_in = 3; h2fValid_in = 1;
        tick(30);
        checks++; if (zBusy !== 1'b1 || zH2fReady !== 1'b0 || zTimeoutCount !== 16'd0) begin
            failures++; $display("FAIL nowd got=%b/%b/%0d exp=1/0/0", zBusy, zH2fReady, zTimeoutCount); end
        idleInputs();
        tick(2);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_watchdog();
        test_boundary_beat();
        test_priority();
        test_reset_mid();
        test_no_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comm_chan_arbiter.md
Name: comm_chan_arbiter

Overview:
- Sits between the host-side channel pipe (7-bit channel address, h2f and f2h valid/ready byte pipes) and NUM_CHAN client endpoints.
- Decodes the channel address and routes each transfer to exactly one client.
- Sinks or fills transfers to unmapped channels.
- Runs a stall watchdog that force-completes any transfer a client leaves hanging, so a dead client can never wedge the host link.

Parameters:
NUM_CHAN, 4, number of client endpoints mapped to channels 0..NUM_CHAN-1 (1..127)
TIMEOUT, 1000, stall cycles before forced completion (0 = watchdog disabled; max 65535)
FILL_BYTE, 8'hFF, byte returned for unmapped-channel reads and timed-out reads

Ports:
clk_in  input  1  system clock, all logic rising-edge
resetN_in  input  1  asynchronous active-low reset
chanAddr_in  input  7  channel selected by host side
h2fData_in  input  8  host-to-FPGA byte
h2fValid_in  input  1  host side offers a byte
h2fReady_out  output  1  byte accepted on this rising edge
f2hData_out  output  8  FPGA-to-host byte
f2hValid_out  output  1  f2hData_out valid; consumed on this edge
f2hReady_in  input  1  host side requests a byte
cliH2fData_out  output  8  shared write data to all clients
cliH2fValid_out  output  NUM_CHAN  one-hot write strobe
cliH2fReady_in  input  NUM_CHAN  per-client write ready
cliF2hData_in  input  8*NUM_CHAN  client read data, client k at [8k+7:8k]
cliF2hValid_in  input  NUM_CHAN  per-client read valid
cliF2hReady_out  output  NUM_CHAN  one-hot read request
timeoutCount_out  output  16  saturating count of forced completions
lastTimeoutChan_out  output  7  channel of most recent forced completion
busy_out  output  1  high in any state other than S_IDLE

Behaviour:
- Reset (asynchronous, resetN_in low):
  - State goes to S_IDLE; sel, stall counter, timeoutCount and lastTimeoutChan are 0.
  - All outputs are low; f2hData_out and cliH2fData_out are 0.
  - Reset mid-transfer abandons the transfer silently.
- Data sharing: cliH2fData_out = h2fData_in at all times. Only the one-hot valid qualifies it.
- States: S_IDLE, S_H2F, S_F2H, S_ABORT. All ready/valid outputs are low in S_IDLE.
- S_IDLE:
  - sel <= chanAddr_in every cycle.
  - h2fValid_in=1 -> S_H2F.
  - else f2hReady_in=1 -> S_F2H.
  - Both high: h2f wins.
  - Minimum transfer latency is therefore 1 cycle after the request.
- S_H2F, sel < NUM_CHAN:
  - cliH2fValid_out[sel] = h2fValid_in.
  - h2fReady_out = cliH2fReady_in[sel].
  - Beat when both are high -> S_IDLE.
- S_H2F, sel >= NUM_CHAN: h2fReady_out=1, byte dropped, -> S_IDLE.
- S_F2H, sel < NUM_CHAN:
  - cliF2hReady_out[sel] = f2hReady_in.
  - f2hValid_out = cliF2hValid_in[sel].
  - f2hData_out = client sel data.
  - Beat when both are high -> S_IDLE.
- S_F2H, sel >= NUM_CHAN: f2hValid_out=1, f2hData_out=FILL_BYTE, -> S_IDLE.
- Request withdrawn (h2fValid_in / f2hReady_in low in S_H2F / S_F2H): -> S_IDLE, no beat, not counted.
- chanAddr_in changes outside S_IDLE are ignored until the next S_IDLE.
- Stall counter:
  - Cleared on entry to S_H2F/S_F2H.
  - Increments each cycle in S_H2F/S_F2H without a beat.
  - Reaching TIMEOUT (and TIMEOUT != 0) -> S_ABORT.
- S_ABORT (exactly 1 cycle):
  - All client strobes are low.
  - If it was an h2f stall: h2fReady_out=1 and the byte is dropped.
  - If it was an f2h stall: f2hValid_out=1 and f2hData_out=FILL_BYTE.
  - timeoutCount increments and saturates at 16'hFFFF.
  - lastTimeoutChan <= sel.
  - -> S_IDLE.
- Client beat on the same cycle the counter hits TIMEOUT: the beat wins, no abort, no count.
- Client strobes are never asserted for more than one client and never in S_IDLE/S_ABORT.

Test Plan:
- Write, ready client: chanAddr=2, h2fValid with 0xA5, client 2 ready -> cliH2fValid_out=4'b0100 one cycle after request; h2fReady_out high the same cycle; client 2 captures 0xA5; back to S_IDLE.
- Read, ready client: chanAddr=1, f2hReady, client 1 valid with 0x3C -> f2hValid_out=1 and f2hData_out=0x3C on cycle 2; cliF2hReady_out=4'b0010 only.
- Unmapped channel (NUM_CHAN=4):
  - chanAddr=0x50 write -> h2fReady_out=1 on cycle 2; no client strobe.
  - chanAddr=0x50 read -> f2hData_out=0xFF with valid.
- Watchdog, TIMEOUT=8: client 3 holds ready low on a write -> S_ABORT after 8 stall cycles; h2fReady_out pulse; timeoutCount=1; lastTimeoutChan=3. Repeat with a read -> 0xFF returned, timeoutCount=2.
- Boundary and priority:
  - Client asserts ready on the exact cycle the count hits TIMEOUT -> normal beat, timeoutCount unchanged.
  - h2fValid and f2hReady simultaneous in S_IDLE -> S_H2F taken.
  - TIMEOUT=0 with a stalled client -> waits indefinitely.
- Reset mid-transfer: assert resetN_in low during S_F2H -> all outputs 0 immediately (asynchronous); counters 0; after release, a normal read to channel 0 completes.
